gradient_compute: RTL
=====================

Name: gradient_compute

Overview:
- Consumes the raster-order dual-frame pixel stream (current and previous frame, same pixel index per beat) from the frame source.
- Produces Lucas-Kanade gradients for every interior pixel:
  - Ix: horizontal central difference
  - Iy: vertical central difference
  - It: temporal difference
- Uses on-chip line buffers. Feeds the downstream structure-tensor accumulation stage.

Parameters:
- PIXEL_WIDTH, 8, unsigned pixel bit width
- IMAGE_WIDTH, 320, pixels per row (>=3)
- IMAGE_HEIGHT, 240, rows per frame (>=3)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pixel_curr  input  PIXEL_WIDTH  current-frame pixel
- pixel_prev  input  PIXEL_WIDTH  previous-frame pixel, same position
- pixel_valid  input  1  input beat qualifier; may be gapped
- frame_done  input  1  upstream end-of-frame pulse
- grad_x  output  PIXEL_WIDTH+1  signed Ix
- grad_y  output  PIXEL_WIDTH+1  signed Iy
- grad_t  output  PIXEL_WIDTH+1  signed It
- grad_col  output  $clog2(IMAGE_WIDTH)  column of centre pixel
- grad_row  output  $clog2(IMAGE_HEIGHT)  row of centre pixel
- grad_valid  output  1  output beat qualifier
- grad_done  output  1  one-cycle end-of-output-frame pulse
- sync_err  output  1  sticky raster/frame_done mismatch flag

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-low on rst_n.
  - All outputs reset to 0.
  - In-column and in-row counters reset to 0.
  - Line-buffer contents are don't-care after reset.
- Input handling:
  - Only beats with pixel_valid=1 are consumed.
  - Each accepted beat advances in_col 0..IMAGE_WIDTH-1, then wraps to 0 and increments in_row 0..IMAGE_HEIGHT-1.
  - After (W-1,H-1), both counters wrap to 0 for the next frame.
- Storage:
  - Two IMAGE_WIDTH-deep line buffers for pixel_curr (rows y-1 and y-2).
  - One IMAGE_WIDTH-deep line buffer for pixel_prev (row y-1).
  - Shift taps give a 3x3 current-frame window and the previous-frame centre pixel.
- Arithmetic, with C = curr and P = prev at centre (cx, cy):
  - Ix = C[cy][cx+1] - C[cy][cx-1]
  - Iy = C[cy+1][cx] - C[cy-1][cx]
  - It = C[cy][cx] - P[cy][cx]
  - Operands are zero-extended to PIXEL_WIDTH+1 and subtracted in two's complement. The result is exact, range [-(2^PW-1), 2^PW-1].
- Output emission:
  - When the beat at (x,y) is accepted with x>=2 and y>=2, the window centred on (x-1, y-1) is complete.
  - The next cycle asserts grad_valid for exactly one cycle, with grad_col=x-1, grad_row=y-1.
  - Latency is 1 cycle from the completing input beat.
- Border pixels (row 0, row H-1, col 0, col W-1) produce no output.
  - Output count per frame is (W-2)*(H-2).
- Gaps: grad_valid stays low on cycles without a completing beat. grad_x/y/t/col/row hold their last values.
- grad_done: pulses the same cycle as the grad_valid for centre (W-2, H-2).
- frame_done check:
  - Input frame_done is expected in the cycle after the beat at (W-1, H-1) was accepted, or later with no intervening valid beats.
  - If frame_done arrives while (in_col, in_row) != (0,0), the block:
    - sets sync_err (sticky until reset),
    - forces both counters to 0,
    - asserts no grad_done for the truncated frame.
  - frame_done coincident with pixel_valid: the counter reset takes priority, and that beat is dropped.
- A valid beat after a wrap starts a new frame. No line-buffer clear is needed, because no output is emitted until y>=2.
- Reset mid-frame: outputs return to 0 immediately, and the next accepted beat is treated as (0,0).

Optional Feature:
- Macro: GRAD_CLAMP_EN
- Defined: Ix, Iy and It are each saturated to [-(2^(PW-1)), 2^(PW-1)-1], i.e. [-128,127] for PW=8, then sign-extended into the PIXEL_WIDTH+1-bit ports. Latency is unchanged.
- Undefined: outputs carry the exact PIXEL_WIDTH+1-bit differences.

Test Plan (W=8, H=6, PW=8 unless noted):
- Horizontal ramp curr=prev=10*x, continuous valid -> 24 grad_valid beats, each Ix=20, Iy=0, It=0; grad_col 1..6, grad_row 1..4; grad_done with the 24th beat.
- Vertical ramp curr=10*y, prev=curr-5 -> every beat Ix=0, Iy=20, It=5; first grad_valid one cycle after accepting beat (2,2), with col=1, row=1.
- Pixel (3,2)=255, all others 0, prev=0; clamp off -> centre (2,2) Ix=+255, centre (4,2) Ix=-255, centre (3,2) It=255. With GRAD_CLAMP_EN: +127, -128, 127 respectively.
- Random 50% pixel_valid gaps, random frames -> outputs bit-match the golden model; count is 24; no grad_valid in cycles after an idle input cycle.
- frame_done injected after 20 accepted beats -> sync_err=1 and stays 1; no grad_done. A following full frame produces 24 correct outputs.
- rst_n deasserted after 30 beats, then a full frame -> all outputs 0 during reset; afterwards 24 correct outputs and grad_done, with sync_err=0.

Source files
------------

// File: rtl/gradient_compute_if.sv
// Pixel-stream in / gradient-stream out bundle for gradient_compute.
// master: frame source side (drives pixels, observes gradients).
// slave : gradient_compute side.
interface gradient_compute_if #(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240
);
  logic [PIXEL_WIDTH-1:0]          pixel_curr;
  logic [PIXEL_WIDTH-1:0]          pixel_prev;
  logic                            pixel_valid;
  logic                            frame_done;
  logic [PIXEL_WIDTH:0]            grad_x;
  logic [PIXEL_WIDTH:0]            grad_y;
  logic [PIXEL_WIDTH:0]            grad_t;
  logic [$clog2(IMAGE_WIDTH)-1:0]  grad_col;
  logic [$clog2(IMAGE_HEIGHT)-1:0] grad_row;
  logic                            grad_valid;
  logic                            grad_done;
  logic                            sync_err;

  modport master (
    output pixel_curr, pixel_prev, pixel_valid, frame_done,
    input  grad_x, grad_y, grad_t, grad_col, grad_row,
           grad_valid, grad_done, sync_err
  );

  modport slave (
    input  pixel_curr, pixel_prev, pixel_valid, frame_done,
    output grad_x, grad_y, grad_t, grad_col, grad_row,
           grad_valid, grad_done, sync_err
  );
endinterface

// File: rtl/gradient_compute.sv
// Lucas-Kanade spatial/temporal gradients (Ix, Iy, It) over a raster
// dual-frame stream using on-chip line buffers. One output per interior
// pixel, one cycle after the beat that completes its 3x3 window.
// Optional macro GRAD_CLAMP_EN saturates each gradient to a signed
// PIXEL_WIDTH range before it is sign-extended onto the ports.
module gradient_compute #(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240
) (
  input logic                clk,
  input logic                rst_n,
  gradient_compute_if.slave  gif
);
  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned GW = PIXEL_WIDTH + 1;
  localparam int unsigned CW = $clog2(IMAGE_WIDTH);
  localparam int unsigned RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;

  // Line buffers: current frame rows y-1 / y-2, previous frame row y-1.
  logic [PW-1:0] lb_c1 [IMAGE_WIDTH];
  logic [PW-1:0] lb_c2 [IMAGE_WIDTH];
  logic [PW-1:0] lb_p1 [IMAGE_WIDTH];

  // Column taps: r0 = row y, r1 = row y-1, r2 = row y-2, p1 = prev row y-1.
  logic [PW-1:0] r0_d1, r1_d1, r1_d2, r2_d1, p1_d1;
  logic [PW-1:0] tap_c1, tap_c2, tap_p1;

  logic          accept;
  logic          col_last, row_last;
  logic          complete;
  logic [GW-1:0] ix_c, iy_c, it_c;

  function automatic logic [GW-1:0] sub_ext(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
    logic [GW-1:0] r;
    r = {1'b0, a} - {1'b0, b};
    return r;
  endfunction

  // Saturate to the signed PW-bit range when the two top bits disagree.
  function automatic logic [GW-1:0] shape(input logic [GW-1:0] d);
    logic [GW-1:0] r;
    r = d;
`ifdef GRAD_CLAMP_EN
    if (!d[GW-1] && d[GW-2]) r = {2'b00, {(PW-1){1'b1}}};
    else if (d[GW-1] && !d[GW-2]) r = {2'b11, {(PW-1){1'b0}}};
`endif
    return r;
  endfunction

  // Beat qualification, window completion and gradient arithmetic.
  always_comb begin
    accept   = gif.pixel_valid & ~gif.frame_done;
    col_last = (in_col == LAST_COL);
    row_last = (in_row == LAST_ROW);
    complete = accept && (in_col >= CW'(2)) && (in_row >= RW'(2));
    tap_c1   = lb_c1[in_col];
    tap_c2   = lb_c2[in_col];
    tap_p1   = lb_p1[in_col];
    ix_c     = shape(sub_ext(tap_c1, r1_d2));
    iy_c     = shape(sub_ext(r0_d1, r2_d1));
    it_c     = shape(sub_ext(r1_d1, p1_d1));
  end

  // Raster position counters and sticky frame_done sync check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col       <= '0;
      in_row       <= '0;
      gif.sync_err <= 1'b0;
    end else if (gif.frame_done) begin
      if ((in_col != '0) || (in_row != '0)) gif.sync_err <= 1'b1;
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (col_last) begin
        in_col <= '0;
        in_row <= row_last ? '0 : in_row + RW'(1);
      end else begin
        in_col <= in_col + CW'(1);
      end
    end
  end

  // Line-buffer writes and column shift taps (contents need no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_c2[in_col] <= tap_c1;
      lb_c1[in_col] <= gif.pixel_curr;
      lb_p1[in_col] <= gif.pixel_prev;
      r0_d1         <= gif.pixel_curr;
      r1_d1         <= tap_c1;
      r1_d2         <= r1_d1;
      r2_d1         <= tap_c2;
      p1_d1         <= tap_p1;
    end
  end

  // Registered gradient outputs; data holds between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gif.grad_x     <= '0;
      gif.grad_y     <= '0;
      gif.grad_t     <= '0;
      gif.grad_col   <= '0;
      gif.grad_row   <= '0;
      gif.grad_valid <= 1'b0;
      gif.grad_done  <= 1'b0;
    end else begin
      gif.grad_valid <= complete;
      gif.grad_done  <= complete && col_last && row_last;
      if (complete) begin
        gif.grad_x   <= ix_c;
        gif.grad_y   <= iy_c;
        gif.grad_t   <= it_c;
        gif.grad_col <= in_col - CW'(1);
        gif.grad_row <= in_row - RW'(1);
      end
    end
  end
endmodule
